rr_arb_mux: RTL and testbench

// - Parametrised N-input, WIDTH-bit arbitrating multiplexer with a registered output stage.
//   It succeeds the fixed 16-bit 4:1 combinational operand mux.
// - Instead of an external select, it picks among valid requesters (round-robin or fixed

---
 rtl/rr_arb_pkg.sv | 10 +
 rtl/rr_grant.sv | 36 +++
 rtl/rr_arb_mux.sv | 80 ++++++++
 tb/tb_rr_arb_mux.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants for the arbitrating operand mux and the write-back bus arbiter.
package rr_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int unsigned DEFAULT_WIDTH  = 16;
  localparam int unsigned DEFAULT_NUM_IN = 4;

endpackage

// File: rtl/rr_grant.sv
// Combinational grant encoder: fixed priority from index 0, or round-robin starting at ptr.
module rr_grant
  import rr_arb_pkg::*;
#(
  parameter  int unsigned NUM_IN = DEFAULT_NUM_IN,
  localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              mode,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any
);

  logic [2*NUM_IN-1:0] req_dbl;
  logic [SEL_W-1:0]    start;
  logic                found;

  // The upper copy covers the wrapped part of the search, so indices below start are
  // still reachable, just at lower priority.
  assign req_dbl = {req, req};
  assign start   = (mode == MODE_RR) ? ptr : '0;
  assign any     = |req;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < 2 * NUM_IN; i++) begin
      if (!found && req_dbl[i] && (i >= int'(start))) begin
        found   = 1'b1;
        gnt_idx = SEL_W'(i % NUM_IN);
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input arbitrating mux with a single registered output stage and valid/ready handshake.
module rr_arb_mux
  import rr_arb_pkg::*;
#(
  parameter  int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter  int unsigned NUM_IN = DEFAULT_NUM_IN,
  localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    MODE,
  input  logic [NUM_IN*WIDTH-1:0] D,
  input  logic [NUM_IN-1:0]       D_VALID,
  output logic [NUM_IN-1:0]       D_READY,
  output logic [WIDTH-1:0]        Y,
  output logic [SEL_W-1:0]        Y_SEL,
  output logic                    Y_VALID,
  input  logic                    Y_READY
);

  logic [WIDTH-1:0] y_q;
  logic [SEL_W-1:0] y_sel_q;
  logic             y_valid_q;
  logic [SEL_W-1:0] ptr_q;

  logic [SEL_W-1:0] gnt_idx;
  logic             any;
  logic             load;
  logic [WIDTH-1:0] sel_data;

  rr_grant #(
    .NUM_IN (NUM_IN)
  ) u_grant (
    .req     (D_VALID),
    .ptr     (ptr_q),
    .mode    (MODE),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Empty stage or a draining beat both free the register this edge.
  assign load = ~y_valid_q | Y_READY;

  assign D_READY = (!RST && load && any) ? (NUM_IN'(1) << gnt_idx) : '0;

  // Lane select by compare so only the granted lane can reach Y.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        sel_data = D[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q       <= '0;
      y_sel_q   <= '0;
      y_valid_q <= 1'b0;
      ptr_q     <= '0;
    end else if (load) begin
      if (any) begin
        y_q       <= sel_data;
        y_sel_q   <= gnt_idx;
        y_valid_q <= 1'b1;
        if (MODE == MODE_RR) begin
          ptr_q <= (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end else begin
        y_valid_q <= 1'b0;
      end
    end
  end

  assign Y       = y_q;
  assign Y_SEL   = y_sel_q;
  assign Y_VALID = y_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus randomized traffic vs a model.
module tb_rr_arb_mux;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic [N*W-1:0] d;
  logic [N-1:0]   dv;
  logic [N-1:0]   d_ready;
  logic [W-1:0]   y;
  logic [1:0]     y_sel;
  logic           y_valid;
  logic           y_ready;

  int checks = 0;
  int errors = 0;

  rr_arb_mux #(
    .WIDTH  (W),
    .NUM_IN (N)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .MODE    (mode),
    .D       (d),
    .D_VALID (dv),
    .D_READY (d_ready),
    .Y       (y),
    .Y_SEL   (y_sel),
    .Y_VALID (y_valid),
    .Y_READY (y_ready)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit           started = 0;
  int           m_ptr   = 0;
  logic [W-1:0] m_y     = '0;
  int           m_sel   = 0;
  bit           m_valid = 0;
  logic [N-1:0] m_cons  = '0;

  // Scan requesters in priority order; -1 when nobody is requesting.
  function automatic int exp_grant();
    int base;
    base = mode ? m_ptr : 0;
    for (int k = 0; k < N; k++) begin
      if (dv[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      started = 1;
      m_y = '0; m_sel = 0; m_valid = 0; m_ptr = 0; m_cons = '0;
    end else if (started) begin
      g = exp_grant();
      m_cons = '0;
      if (!m_valid || y_ready) begin
        if (g >= 0) begin
          m_y = d[g*W +: W];
          m_sel = g;
          m_valid = 1;
          m_cons[g] = 1'b1;
          if (mode) m_ptr = (g + 1) % N;
        end else begin
          m_valid = 0;
        end
      end
    end
  end

  // Compare process: outputs checked every cycle once the model is anchored by reset.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_rdy;
    if (started) begin
      exp_rdy = '0;
      if (!rst && (!m_valid || y_ready)) begin
        g = exp_grant();
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      checks++;
      if (y_valid !== m_valid) begin
        errors++;
        $display("FAIL model_y_valid t=%0t got %b exp %b", $time, y_valid, m_valid);
      end
      checks++;
      if (y !== m_y) begin
        errors++;
        $display("FAIL model_y t=%0t got %h exp %h", $time, y, m_y);
      end
      checks++;
      if (int'(y_sel) != m_sel || $isunknown(y_sel)) begin
        errors++;
        $display("FAIL model_y_sel t=%0t got %0d exp %0d", $time, y_sel, m_sel);
      end
      checks++;
      if (d_ready !== exp_rdy) begin
        errors++;
        $display("FAIL model_d_ready t=%0t got %b exp %b", $time, d_ready, exp_rdy);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h exp %h", name, $time, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b1; y_ready = 1'b1; dv = 4'b1111;
    for (int i = 0; i < N; i++) d[i*W +: W] = 16'hA000 + 16'(i);

    // Reset held two edges with every requester valid
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_y_valid", 32'(y_valid), 32'h0);
    chk("rst_d_ready", 32'(d_ready), 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("first_grant", 32'(d_ready), 32'h1);

    // Round-robin fairness
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_y", 32'(y), 32'hA000 + 32'(k % N));
      chk("rr_sel", 32'(y_sel), 32'(k % N));
    end

    // Backpressure: three stalled cycles then release with no bubble
    @(posedge clk); #2 y_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_y", 32'(y), 32'hA001);
      chk("stall_sel", 32'(y_sel), 32'h1);
      chk("stall_d_ready", 32'(d_ready), 32'h0);
    end
    @(posedge clk); #2 y_ready = 1'b1;
    @(negedge clk);
    chk("release_d_ready", 32'(d_ready), 32'h4);
    @(negedge clk);
    chk("release_y", 32'(y), 32'hA002);
    chk("release_valid", 32'(y_valid), 32'h1);

    // Fixed priority starves requester 3
    @(posedge clk); #2 mode = 1'b0; dv = 4'b1010;
    @(negedge clk);
    chk("fix_d_ready", 32'(d_ready), 32'h2);
    chk("fix_prev_y", 32'(y), 32'hA003);
    repeat (3) begin
      @(negedge clk);
      chk("fix_sel", 32'(y_sel), 32'h1);
      chk("fix_y", 32'(y), 32'hA001);
    end

    // Wrap: grant 2 leaves pointer at 3, lone requester 0 wins and pointer goes to 1
    @(posedge clk); #2 mode = 1'b1; dv = 4'b0100;
    @(posedge clk); #2 dv = 4'b0001;
    @(negedge clk);
    chk("wrap_sel2", 32'(y_sel), 32'h2);
    chk("wrap_d_ready", 32'(d_ready), 32'h1);
    @(posedge clk); #2 dv = 4'b0000;
    @(negedge clk);
    chk("wrap_sel0", 32'(y_sel), 32'h0);
    chk("wrap_y0", 32'(y), 32'hA000);
    @(posedge clk); #2 dv = 4'b1111;
    @(negedge clk);
    chk("empty_valid", 32'(y_valid), 32'h0);
    chk("empty_hold_y", 32'(y), 32'hA000);
    chk("ptr1_d_ready", 32'(d_ready), 32'h2);
    @(negedge clk);
    chk("ptr1_sel", 32'(y_sel), 32'h1);

    // Reset in the middle of a stall drops the held beat
    @(posedge clk); #2 y_ready = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid_before", 32'(y_valid), 32'h1);
    chk("mid_rst_d_ready", 32'(d_ready), 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(y_valid), 32'h0);
    chk("mid_rst_y", 32'(y), 32'h0);
    chk("mid_rst_ptr0", 32'(d_ready), 32'h1);

    // Randomized traffic; requesters hold their beat until consumed
    repeat (3000) begin
      @(posedge clk); #2;
      for (int i = 0; i < N; i++) begin
        if (!dv[i] || m_cons[i]) begin
          dv[i] = ($urandom_range(0, 3) != 0);
          d[i*W +: W] = 16'($urandom);
        end
      end
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      y_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
